// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter in front of the async FIFO write port.
// Optional statistics counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW = $clog2(MAX_BURST) + 1
) (
  input  logic                          write_clk,
  input  logic                          write_reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          write_full,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          grant_valid,
  output logic [IW-1:0]                 grant_index,
  output logic [15:0]                   word_count,
  output logic [15:0]                   stall_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                state_r, state_s;
  logic [IW-1:0]         grant_index_r, grant_index_s;
  logic [IW-1:0]         last_grant_r, last_grant_s;
  logic [IW-1:0]         pick_idx_s;
  logic [BW-1:0]         burst_cnt_r, burst_cnt_s;
  logic                  active_s;
  logic                  sel_valid_s;
  logic                  burst_done_s;
  int                    best_dist_s;
  logic [DATA_WIDTH-1:0] req_word_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Outputs are gated by reset so an aborted burst never writes in the reset cycle.
  assign active_s     = write_reset_n & (state_r == BURST);
  assign sel_valid_s  = req_valid[grant_index_r];
  assign burst_done_s = req_last[grant_index_r] | (burst_cnt_r == BW'(MAX_BURST - 1));
  assign grant_valid  = active_s;
  assign grant_index  = write_reset_n ? grant_index_r : {IW{1'b0}};
  assign write_enable = active_s & sel_valid_s & ~write_full;
  assign write_data   = active_s ? req_word_s[grant_index_r] : {DATA_WIDTH{1'b0}};

  // One-hot ready for the current grant holder on a transfer.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (write_enable && (grant_index_r == IW'(i))) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Round-robin pick: smallest forward distance from the previous holder wins.
  always_comb begin
    best_dist_s = NUM_REQ;
    pick_idx_s  = {IW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] &&
          (((i + NUM_REQ - int'(last_grant_r) - 1) % NUM_REQ) < best_dist_s)) begin
        best_dist_s = (i + NUM_REQ - int'(last_grant_r) - 1) % NUM_REQ;
        pick_idx_s  = IW'(i);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Next-state logic; a full FIFO simply freezes the burst.
  always_comb begin
    state_s       = state_r;
    grant_index_s = grant_index_r;
    last_grant_s  = last_grant_r;
    burst_cnt_s   = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          state_s       = BURST;
          grant_index_s = pick_idx_s;
          burst_cnt_s   = {BW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (!sel_valid_s) begin
          state_s      = IDLE;
          last_grant_s = grant_index_r;
          burst_cnt_s  = {BW{1'b0}};
        end else if (write_enable) begin
          if (burst_done_s) begin
            state_s      = IDLE;
            last_grant_s = grant_index_r;
            burst_cnt_s  = {BW{1'b0}};
          end else begin
            burst_cnt_s = burst_cnt_r + BW'(1);
          end
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge write_clk) begin
    if (!write_reset_n) begin
      state_r       <= IDLE;
      grant_index_r <= {IW{1'b0}};
      last_grant_r  <= IW'(NUM_REQ - 1);
      burst_cnt_r   <= {BW{1'b0}};
    end else begin
      state_r       <= state_s;
      grant_index_r <= grant_index_s;
      last_grant_r  <= last_grant_s;
      burst_cnt_r   <= burst_cnt_s;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] word_count_r;
  logic [15:0] stall_count_r;
  logic        stall_s;

  assign stall_s = active_s & sel_valid_s & write_full;

  // Word counter wraps; stall counter saturates.
  always_ff @(posedge write_clk) begin
    if (!write_reset_n) begin
      word_count_r  <= 16'h0000;
      stall_count_r <= 16'h0000;
    end else begin
      if (write_enable) begin
        word_count_r <= word_count_r + 16'h0001;
      end else begin
        word_count_r <= word_count_r;
      end
      if (stall_s && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'h0001;
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign word_count  = word_count_r;
  assign stall_count = stall_count_r;
`else
  assign word_count  = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the async FIFO write-side logic (write_enable / write data / write_full) among NUM_REQ requesters.
- Typical requesters: APB register writes and the I2C receive shifter.
- Round-robin grant with bounded bursts; only lets a word through when the FIFO is not full.
- Sits entirely in the FIFO write clock domain, directly in front of the FIFO write pointer / full logic.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 8, FIFO word width.
- MAX_BURST, 4, max words accepted per grant before forced re-arbitration (1..16).

Ports:
- write_clk  in  1  FIFO write clock.
- write_reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester word available.
- req_last  in  NUM_REQ  per-requester: current word ends its burst.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester: word accepted this cycle.
- write_full  in  1  FIFO full flag from write-side logic.
- write_enable  out  1  FIFO write strobe.
- write_data  out  DATA_WIDTH  FIFO write data.
- grant_valid  out  1  a requester currently holds the port.
- grant_index  out  clog2(NUM_REQ) (min 1)  index of current grant holder.
- word_count  out  16  total words written (optional feature).
- stall_count  out  16  full-stall cycles (optional feature).

Behaviour:
- Reset (write_reset_n low at a write_clk edge):
  - state=IDLE, grant_valid=0, grant_index=0, last_grant=NUM_REQ-1, burst_cnt=0, counters=0.
  - Reset mid-burst aborts the burst; no write in that cycle.
- Combinational outputs:
  - write_enable = grant_valid & req_valid[grant_index] & ~write_full.
  - req_ready[i] = write_enable & (grant_index==i); all other bits 0.
  - write_data = req_data slice of grant_index whenever grant_valid, else 0.
  - A transfer occurs when write_enable=1.
- Requester rule: once req_valid[i] is asserted it holds, with stable data, until req_ready[i]. The arbiter never writes a word without a matching ready.
- FSM IDLE:
  - If any req_valid: pick the first set bit searching last_grant+1, +2, ... modulo NUM_REQ.
  - Next cycle: state=BURST, grant_valid=1, grant_index=winner, burst_cnt=0.
  - If no req_valid: stay IDLE. No writes occur in IDLE.
- FSM BURST, per cycle:
  - Transfer with (req_last=1 or burst_cnt==MAX_BURST-1): go to IDLE, grant_valid=0, last_grant=grant_index.
  - Transfer otherwise: burst_cnt+1.
  - req_valid[grant_index]=0: go to IDLE, last_grant=grant_index; burst ends with no transfer that cycle.
  - write_full=1 with valid held: stay in BURST, burst_cnt unchanged, no ready. Arbitrarily long stalls are allowed.
- Latency:
  - req_valid seen in IDLE at cycle t gives the earliest write at t+1.
  - One IDLE bubble cycle between consecutive grants.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0; each gets MAX_BURST words per turn.
- Simultaneous events:
  - req_last together with write_full: no transfer, burst continues.
  - New valids arriving during BURST wait for IDLE.
- burst_cnt width is clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - word_count increments on every transfer and wraps at 2^16.
  - stall_count increments on each cycle with grant_valid & req_valid[grant_index] & write_full, saturating at 16'hFFFF.
  - Both clear on reset.
- Undefined: both ports are present and tied to 0; no counter flops are built.

Test Plan:
- Reset, then req_valid=01, data 8'hA5, req_last=1, write_full=0 -> grant_index=0 at cycle 1; write_enable=1 with write_data=A5 at cycle 1; req_ready=01; IDLE at cycle 2.
- Both requesters valid continuously, req_last=0, MAX_BURST=4 -> words from sequence 0,0,0,0,(bubble),1,1,1,1,(bubble),0...; exactly 4 per grant.
- Requester 0 granted and write_full held high for 5 cycles mid-burst -> no write_enable, burst_cnt frozen; stall_count=5 with macro; burst resumes after full drops and completes remaining words.
- Requester 1 drops req_valid after 2 words in a burst -> arbiter goes IDLE; last_grant=1; a pending requester 0 is granted next.
- write_reset_n low during BURST with write_full=0 and valid held -> no write in the reset cycle; all outputs 0; the next grant goes to requester 0 (last_grant=NUM_REQ-1).
- NUM_REQ=3, only requesters 0 and 2 valid, last_grant=0 -> requester 1 skipped; grant_index=2.
